// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor computing diff = a - b - bin.
// One full-subtractor cell is reused each clock, LSB first, with the borrow
// held in a flop between bits. Operands are captured on an accepted start.
// The result is delivered with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..16)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   a      minuend, captured on acceptance
//   b      subtrahend, captured on acceptance
//   bin    borrow-in, captured on acceptance
//   busy   high from the cycle after acceptance through the done cycle
//   done   one-cycle pulse; diff/bout are valid in this cycle
//   diff   result, held until the next operation completes
//   bout   final borrow-out (1 = unsigned a < b + bin)
//   ovf    signed overflow, only when SUB_OVF_EN is defined
//
// Build option: define SUB_OVF_EN to add the signed-overflow output.

module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;

`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ brw;
        brw_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        // New bit enters at the MSB so the LSB-first stream ends up in place.
        res_nxt = {d_bit, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        brw    <= bin;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy   <= 1'b1;
                        state  <= StRun;
`ifdef SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    brw    <= brw_nxt;
                    res_sh <= res_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == CNT_LAST) begin
                        // Last bit: publish the result alongside the done pulse.
                        cnt   <= '0;
                        state <= StDone;
                        done  <= 1'b1;
                        diff  <= res_nxt;
                        bout  <= brw_nxt;
`ifdef SUB_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results from
// an arithmetic reference model; a monitor pops and compares on each done.

module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass = 0;

    exp_t         exp_q[$];
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int   r, sa, sb, sr;
        r      = av - bv - bi;
        e.diff = W'(r & ((1 << W) - 1));
        e.bout = (av < bv + bi);
        sa     = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb     = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        sr     = sa - sb - bi;
        e.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("diff", int'(diff), int'(e.diff));
                check("bout", int'(bout), int'(e.bout));
`ifdef SUB_OVF_EN
                check("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    // One operation; optionally pulses start in RUN cycle 2 and in the DONE cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input bit pulse);
        exp_t e;
        e = model(int'(av), int'(bv), int'(bi));
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        bin = bi;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                check("done_low_in_run", int'(done), 0);
                check("busy_in_run", int'(busy), 1);
                check("diff_stable", int'(diff), int'(last_diff));
                check("bout_stable", int'(bout), int'(last_bout));
            end else begin
                check("done_at_latency", int'(done), 1);
                check("busy_in_done", int'(busy), 1);
            end
            start = pulse && (k == 2 || k == W + 1);
            if (start) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", int'(busy), 0);
        check("done_after_done", int'(done), 0);
        check("diff_held", int'(diff), int'(e.diff));
        check("bout_held", int'(bout), int'(e.bout));
        last_diff = e.diff;
        last_bout = e.bout;
    endtask

    task automatic reset_mid_run();
        exp_t e;
        e = model(9, 3, 0);
        @(posedge clk);
        #1;
        a = 4'd9;
        b = 4'd3;
        bin = 1'b0;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
`ifdef SUB_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif
        void'(exp_q.pop_back());
        last_diff = '0;
        last_bout = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("no_done_after_reset", int'(done), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_bout", int'(bout), 0);
`ifdef SUB_OVF_EN
        check("reset_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0, 1'b0);
        run_op(4'd3, 4'd9, 1'b0, 1'b0);
        run_op(4'd0, 4'd0, 1'b1, 1'b0);
        run_op(4'hF, 4'hF, 1'b0, 1'b0);
        run_op(4'd5, 4'd2, 1'b1, 1'b1);
        reset_mid_run();
        run_op(4'd9, 4'd3, 1'b0, 1'b0);
        run_op(4'h8, 4'h1, 1'b0, 1'b0);
        run_op(4'h7, 4'h1, 1'b0, 1'b0);
        run_op(4'h7, 4'h8, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
